// File: rtl/store_buffer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// store_buffer_if : CPU request/response channel into the store buffer
// rev 1.0
// ------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_memop;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata;
  logic          rvalid;

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata,
    input  req_ready, rdata, rvalid
  );

  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata,
    output req_ready, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// store_buffer : posted-write FIFO between CPU load/store path and memory
// rev 1.0
// ------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_buffer_if.slave          req,
  input  logic                   flush_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   mem_wren_o,
  output logic                   mem_en_o,
  output logic [2:0]             mem_op_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [31:0]            mem_din_o,
  input  logic [31:0]            mem_dout_i
);
  localparam int         PW   = $clog2(DEPTH);
  localparam int         CW   = PW + 1;
  localparam logic [2:0] OP_W = 3'b000;
  localparam logic [2:0] OP_B = 3'b001;
  localparam logic [2:0] OP_H = 3'b010;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [2:0]       op_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [2:0]       last_op_q;
  logic [AW-1:0]    last_addr_q;
  logic [31:0]      last_din_q;

  logic          full;
  logic          conflict;
  logic          st_ok;
  logic          ld_ok;
  logic          st_acc;
  logic          ld_acc;
  logic          op_legal;
  logic          push;
  logic          drain;
  logic [AW:0]   ld_lo;
  logic [AW:0]   ld_hi;

  // Last byte of an access, one bit wider so spans near the top never wrap.
  function automatic logic [AW:0] span_end(input logic [AW-1:0] a, input logic [2:0] op);
    logic [AW:0] off;
    case (op[1:0])
      2'b01:   off = '0;
      2'b10:   off = (AW+1)'(1);
      default: off = (AW+1)'(3);
    endcase
    return {1'b0, a} + off;
  endfunction

  assign ld_lo = {1'b0, req.req_addr};
  assign ld_hi = span_end(req.req_addr, req.req_memop);

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ld_lo <= span_end(addr_q[i], op_q[i]))
                     && ({1'b0, addr_q[i]} <= ld_hi)) begin
        conflict = 1'b1;
      end
    end
  end

  assign full     = (count_q == CW'(DEPTH));
  assign op_legal = (req.req_memop == OP_W) || (req.req_memop == OP_B) || (req.req_memop == OP_H);

  // rst_n gating keeps the request port and memory quiet while reset is held.
  assign st_ok  = rst_n && !full && !flush_i;
  assign ld_ok  = rst_n && !conflict && !flush_i && !full;
  assign st_acc = req.req_valid && req.req_we && st_ok;
  assign ld_acc = req.req_valid && !req.req_we && ld_ok;
  assign push   = st_acc && op_legal;
  assign drain  = (count_q != '0) && !ld_acc;

  assign req.req_ready = req.req_we ? st_ok : ld_ok;
  assign req.rdata     = mem_dout_i;
  assign req.rvalid    = ld_acc;

  assign mem_en_o   = ld_acc || drain;
  assign mem_wren_o = drain;
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  always_comb begin
    mem_op_o   = last_op_q;
    mem_addr_o = last_addr_q;
    mem_din_o  = last_din_q;
    if (ld_acc) begin
      mem_op_o   = req.req_memop;
      mem_addr_o = req.req_addr;
    end else if (drain) begin
      mem_op_o   = op_q[head_q];
      mem_addr_o = addr_q[head_q];
      mem_din_o  = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      last_op_q   <= '0;
      last_addr_q <= '0;
      last_din_q  <= '0;
    end else begin
      if (push) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (drain) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (mem_en_o) begin
        last_op_q   <= mem_op_o;
        last_addr_q <= mem_addr_o;
        last_din_q  <= mem_din_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= req.req_addr;
      op_q[tail_q]   <= req.req_memop;
      data_q[tail_q] <= req.req_wdata;
    end
  end

  a_store_op_legal: assert property (@(posedge clk) disable iff (!rst_n) st_acc |-> op_legal);

endmodule
`default_nettype wire
